// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_pkg
// Description : Constants and types shared by the filter_decoder data path.
//               It holds the sample width default, the tap shift amounts of
//               the shift-weighted averaging filter, and the handshake state
//               encoding. A future encoder can reuse the same constants.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_pkg;

    // Sample width; all decode arithmetic wraps modulo 2^DATA_W.
    localparam int DATA_W = 8;

    // Right-shift applied to x[n-1], x[n-2] and x[n-3] respectively.
    localparam int SH1 = 1;
    localparam int SH2 = 2;
    localparam int SH3 = 3;

    // Output register occupancy.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : filter_pkg
`default_nettype wire

// File: rtl/filter_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : filter_decoder_if
// Description : Stream bundle around the filter decoder. It carries an input
//               valid/ready channel for the filtered samples, an output
//               valid/ready channel for the reconstructed samples, and the
//               flush strobe.
//   master : upstream/downstream side (drives in_*, flush, out_ready)
//   slave  : decoder side (drives in_ready, out_valid, out_data)
// Revision    : 1.0 - initial release
// ============================================================================
interface filter_decoder_if #(
    parameter int DATA_W = filter_pkg::DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface : filter_decoder_if
`default_nettype wire

// File: rtl/filter_dec_hist.sv
`default_nettype none
// ============================================================================
// Module      : filter_dec_hist
// Description : Three-deep history of decoded samples, x[n-1]..x[n-3].
//               When i_clear and i_shift_en are both set, the history is
//               cleared and i_din becomes the only surviving sample in h1.
//   clk, rst      : clock, asynchronous active-low reset
//   i_shift_en    : shift i_din into h1 (h3<-h2, h2<-h1)
//   i_clear       : synchronous clear of the history
//   i_din         : newly decoded sample
//   o_h1..o_h3    : x[n-1], x[n-2], x[n-3]
// Revision    : 1.0 - initial release
// ============================================================================
module filter_dec_hist #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_shift_en,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_din,
    output logic      [WIDTH-1:0] o_h1,
    output logic      [WIDTH-1:0] o_h2,
    output logic      [WIDTH-1:0] o_h3
);

    logic [WIDTH-1:0] r_h1;
    logic [WIDTH-1:0] r_h2;
    logic [WIDTH-1:0] r_h3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h1 <= '0;
            r_h2 <= '0;
            r_h3 <= '0;
        end else if (i_clear) begin
            // A sample accepted with the clear was decoded against zero
            // history, so it is kept as the new x[n-1].
            r_h1 <= i_shift_en ? i_din : '0;
            r_h2 <= '0;
            r_h3 <= '0;
        end else if (i_shift_en) begin
            r_h1 <= i_din;
            r_h2 <= r_h1;
            r_h3 <= r_h2;
        end
    end

    assign o_h1 = r_h1;
    assign o_h2 = r_h2;
    assign o_h3 = r_h3;

endmodule : filter_dec_hist
`default_nettype wire

// File: rtl/filter_decoder.sv
`default_nettype none
// ============================================================================
// Module      : filter_decoder
// Description : Streaming inverse of the 4-tap shift-weighted averaging
//               filter y = x + (x1>>1) + (x2>>2) + (x3>>3) (mod 2^DATA_W).
//               It reconstructs x = y - (h1>>1) - (h2>>2) - (h3>>3) behind a
//               one-entry output register with valid/ready handshakes.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : filter_decoder_if.slave (in_*, flush, out_*)
//   sample_cnt : 16-bit accepted-sample counter, present only when the
//                FILTER_DEC_CNT_EN macro is defined
// Revision    : 1.0 - initial release
// ============================================================================
module filter_decoder
    import filter_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    filter_decoder_if.slave   bus
`ifdef FILTER_DEC_CNT_EN
    ,
    output logic [15:0]       sample_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_h1_raw;
    logic [DATA_W-1:0] w_h2_raw;
    logic [DATA_W-1:0] w_h3_raw;
    logic [DATA_W-1:0] w_h1;
    logic [DATA_W-1:0] w_h2;
    logic [DATA_W-1:0] w_h3;
    logic [DATA_W-1:0] w_x;

    // ------------------------------------------------------------------------
    // Decode data path
    // ------------------------------------------------------------------------
    filter_dec_hist #(
        .WIDTH (DATA_W)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (w_accept),
        .i_clear    (bus.flush),
        .i_din      (w_x),
        .o_h1       (w_h1_raw),
        .o_h2       (w_h2_raw),
        .o_h3       (w_h3_raw)
    );

    // A sample accepted together with flush sees an already-cleared history,
    // matching the encoder's first output after its own reset.
    assign w_h1 = bus.flush ? '0 : w_h1_raw;
    assign w_h2 = bus.flush ? '0 : w_h2_raw;
    assign w_h3 = bus.flush ? '0 : w_h3_raw;

    assign w_x = bus.in_data - (w_h1 >> SH1) - (w_h2 >> SH2) - (w_h3 >> SH3);

    // ------------------------------------------------------------------------
    // Output-register handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        case (r_state)
            EMPTY: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready && !bus.in_valid) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data <= '0;
        end else if (w_accept) begin
            r_out_data <= w_x;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_out_data;

`ifdef FILTER_DEC_CNT_EN
    // Counts accepted samples; wraps naturally and survives flush.
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign sample_cnt = r_cnt;
`endif

endmodule : filter_decoder
`default_nettype wire
